// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes the serial line, finds the start bit,
// samples every bit at its midpoint on the oversampling tick, and presents each
// word in parallel with a one-cycle valid strobe and parity/framing error flags.
module uart_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic              PAR_EN   = 1'(PARITY_EN);
  localparam logic              PAR_ODD  = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Line synchronizer, idles high so reset does not look like a start bit
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // Frame state
  state_t                r_state;
  logic                  r_armed;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;

  // Registered outputs
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_busy;

  // Next-state values
  state_t                w_state_nx;
  logic                  w_armed_nx;
  logic [TICK_W-1:0]     w_tick_cnt_nx;
  logic [BIT_W-1:0]      w_bit_cnt_nx;
  logic [DATA_WIDTH-1:0] w_shift_nx;
  logic                  w_par_bit_nx;
  logic [DATA_WIDTH-1:0] w_data_out_nx;
  logic                  w_data_valid_nx;
  logic                  w_parity_err_nx;
  logic                  w_frame_err_nx;

  logic                  w_par_mismatch;

  assign w_rx_s = r_sync2;

  // Parity check over the captured data plus the received parity bit
  assign w_par_mismatch = PAR_EN & (((^r_shift) ^ r_par_bit) != PAR_ODD);

  // Two-flop synchronizer on the asynchronous rx pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_armed      <= w_armed_nx;
      r_tick_cnt   <= w_tick_cnt_nx;
      r_bit_cnt    <= w_bit_cnt_nx;
      r_shift      <= w_shift_nx;
      r_par_bit    <= w_par_bit_nx;
      r_data_out   <= w_data_out_nx;
      r_data_valid <= w_data_valid_nx;
      r_parity_err <= w_parity_err_nx;
      r_frame_err  <= w_frame_err_nx;
      r_busy       <= (w_state_nx != ST_IDLE);
    end
  end

  // Next-state and output decode; everything advances only on sample_tick
  always_comb begin
    w_state_nx      = r_state;
    w_armed_nx      = r_armed;
    w_tick_cnt_nx   = r_tick_cnt;
    w_bit_cnt_nx    = r_bit_cnt;
    w_shift_nx      = r_shift;
    w_par_bit_nx    = r_par_bit;
    w_data_out_nx   = r_data_out;
    w_data_valid_nx = 1'b0;
    w_parity_err_nx = r_parity_err;
    w_frame_err_nx  = r_frame_err;

    if (sample_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          // A start edge only counts once the line has been seen high
          if (w_rx_s) begin
            w_armed_nx = 1'b1;
          end else if (r_armed) begin
            w_state_nx    = ST_START;
            w_tick_cnt_nx = '0;
            w_armed_nx    = 1'b0;
          end
        end

        ST_START: begin
          if (r_tick_cnt == TICK_MID) begin
            if (!w_rx_s) begin
              w_state_nx    = ST_DATA;
              w_tick_cnt_nx = '0;
              w_bit_cnt_nx  = '0;
            end else begin
              w_state_nx    = ST_IDLE;
              w_armed_nx    = 1'b1;
              w_tick_cnt_nx = '0;
            end
          end else begin
            w_tick_cnt_nx = r_tick_cnt + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (r_tick_cnt == TICK_END) begin
            w_shift_nx    = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            w_tick_cnt_nx = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nx = PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_nx = r_tick_cnt + TICK_W'(1);
          end
        end

        ST_PARITY: begin
          if (r_tick_cnt == TICK_END) begin
            w_par_bit_nx  = w_rx_s;
            w_tick_cnt_nx = '0;
            w_state_nx    = ST_STOP;
          end else begin
            w_tick_cnt_nx = r_tick_cnt + TICK_W'(1);
          end
        end

        ST_STOP: begin
          // Publish the word; a low stop bit leaves the receiver disarmed
          if (r_tick_cnt == TICK_END) begin
            w_data_out_nx   = r_shift;
            w_frame_err_nx  = ~w_rx_s;
            w_parity_err_nx = w_par_mismatch;
            w_data_valid_nx = 1'b1;
            w_armed_nx      = w_rx_s;
            w_tick_cnt_nx   = '0;
            w_state_nx      = ST_IDLE;
          end else begin
            w_tick_cnt_nx = r_tick_cnt + TICK_W'(1);
          end
        end

        default: begin
          w_state_nx    = ST_IDLE;
          w_armed_nx    = 1'b0;
          w_tick_cnt_nx = '0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule
